// File: rtl/tage_pkg.sv
// rtl/tage_pkg.sv - shared types and constants for the TAGE update engine
package tage_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UPD_PROV,
    ALLOC,
    U_DEC,
    SWEEP
  } state_t;

  localparam int MAX_COMPONENTS = 8;
  typedef logic [$clog2(MAX_COMPONENTS)-1:0] comp_idx_t;

  // Fibonacci taps for x^16+x^14+x^13+x^11+1 (bits 15,13,12,10)
  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'h0001;

  function automatic int weak_taken(input int ctr_width);
    return 1 << (ctr_width - 1);
  endfunction

  function automatic int weak_not_taken(input int ctr_width);
    return (1 << (ctr_width - 1)) - 1;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_POLY)};
  endfunction

endpackage

// File: rtl/tage_updater_if.sv
// rtl/tage_updater_if.sv - resolved-branch record in, table write/clear strobes out
interface tage_updater_if #(
  parameter int N_COMPONENTS = 5,
  parameter int CTR_WIDTH    = 3,
  parameter int U_WIDTH      = 2,
  parameter int TAG_WIDTH    = 8,
  parameter int INDEX_WIDTH  = 10
);
  localparam int CW = $clog2(N_COMPONENTS);

  logic                              update_valid;
  logic                              update_ready;
  logic                              actual_taken;
  logic                              taken_predicted;
  logic                              alt_taken;
  logic [CW-1:0]                     provider_index;
  logic [N_COMPONENTS*INDEX_WIDTH-1:0] entry_index;
  logic [N_COMPONENTS*TAG_WIDTH-1:0] entry_tag;
  logic [CTR_WIDTH-1:0]              provider_ctr;
  logic [U_WIDTH-1:0]                provider_u;
  logic [N_COMPONENTS*U_WIDTH-1:0]   u_values;

  logic                              wr_valid;
  logic [CW-1:0]                     wr_component;
  logic [INDEX_WIDTH-1:0]            wr_index;
  logic                              wr_ctr_en;
  logic                              wr_u_en;
  logic                              wr_tag_en;
  logic [CTR_WIDTH-1:0]              wr_ctr;
  logic [U_WIDTH-1:0]                wr_u;
  logic [TAG_WIDTH-1:0]              wr_tag;
  logic                              u_clear_valid;
  logic [INDEX_WIDTH-1:0]            u_clear_index;

  modport master (
    output update_valid, actual_taken, taken_predicted, alt_taken, provider_index,
           entry_index, entry_tag, provider_ctr, provider_u, u_values,
    input  update_ready, wr_valid, wr_component, wr_index, wr_ctr_en, wr_u_en,
           wr_tag_en, wr_ctr, wr_u, wr_tag, u_clear_valid, u_clear_index
  );

  modport slave (
    input  update_valid, actual_taken, taken_predicted, alt_taken, provider_index,
           entry_index, entry_tag, provider_ctr, provider_u, u_values,
    output update_ready, wr_valid, wr_component, wr_index, wr_ctr_en, wr_u_en,
           wr_tag_en, wr_ctr, wr_u, wr_tag, u_clear_valid, u_clear_index
  );

endinterface

// File: rtl/tage_alloc_picker.sv
// rtl/tage_alloc_picker.sv - chooses the tagged component to allocate on a mispredict
module tage_alloc_picker
  import tage_pkg::*;
#(
  parameter int N_COMPONENTS = 5,
  parameter int U_WIDTH      = 2
) (
  input  logic [N_COMPONENTS*U_WIDTH-1:0] u_values,
  input  comp_idx_t                       provider,
  input  logic                            lfsr_bit,
  output logic                            found,
  output comp_idx_t                       chosen
);

  comp_idx_t  first_free;
  comp_idx_t  second_free;
  logic [3:0] n_free;

  // Random skip to the second free slot spreads allocations over longer histories
  always_comb begin
    first_free  = '0;
    second_free = '0;
    n_free      = '0;
    for (int j = 0; j < N_COMPONENTS; j++) begin
      if (comp_idx_t'(j) > provider && u_values[j*U_WIDTH +: U_WIDTH] == '0) begin
        if (n_free == 4'd0)
          first_free = comp_idx_t'(j);
        else if (n_free == 4'd1)
          second_free = comp_idx_t'(j);
        n_free = n_free + 4'd1;
      end
    end
    found  = (n_free != 4'd0);
    chosen = (lfsr_bit && n_free >= 4'd2) ? second_free : first_free;
  end

endmodule

// File: rtl/tage_updater.sv
// rtl/tage_updater.sv - serialises TAGE provider update, allocation, u decay and u sweep
module tage_updater
  import tage_pkg::*;
#(
  parameter int N_COMPONENTS        = 5,
  parameter int CTR_WIDTH           = 3,
  parameter int U_WIDTH             = 2,
  parameter int TAG_WIDTH           = 8,
  parameter int INDEX_WIDTH         = 10,
  parameter int U_RESET_PERIOD_LOG2 = 18
) (
  input logic           clk,
  input logic           rst,
  tage_updater_if.slave bus
);

  localparam int CW = $clog2(N_COMPONENTS);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;
  localparam logic [U_WIDTH-1:0]   U_MAX   = '1;
  localparam logic [CTR_WIDTH-1:0] WEAK_T  = CTR_WIDTH'(weak_taken(CTR_WIDTH));
  localparam logic [CTR_WIDTH-1:0] WEAK_NT = CTR_WIDTH'(weak_not_taken(CTR_WIDTH));
  localparam comp_idx_t            LAST_COMP = comp_idx_t'(N_COMPONENTS - 1);

  state_t                              state;
  logic                                lat_actual;
  logic                                lat_predicted;
  comp_idx_t                           lat_prov;
  comp_idx_t                           dec_comp;
  comp_idx_t                           dec_target;
  comp_idx_t                           in_prov;
  comp_idx_t                           pick_comp;
  logic                                pick_found;
  logic [N_COMPONENTS*INDEX_WIDTH-1:0] lat_index;
  logic [N_COMPONENTS*TAG_WIDTH-1:0]   lat_tag;
  logic [N_COMPONENTS*U_WIDTH-1:0]     lat_uv;
  logic [U_RESET_PERIOD_LOG2-1:0]      period_cnt;
  logic                                sweep_pending;
  logic [15:0]                         lfsr;
  logic [CTR_WIDTH-1:0]                prov_ctr_next;
  logic [U_WIDTH-1:0]                  prov_u_next;
  logic                                prov_u_en;

  assign bus.update_ready = (state == IDLE);
  assign in_prov          = comp_idx_t'(bus.provider_index);
  assign dec_target       = (state == UPD_PROV) ? lat_prov + 1'b1 : dec_comp + 1'b1;

  // Provider write is formed from the live record so it can be registered at accept
  always_comb begin
    prov_ctr_next = bus.provider_ctr;
    if (bus.actual_taken && bus.provider_ctr != CTR_MAX)
      prov_ctr_next = bus.provider_ctr + 1'b1;
    else if (!bus.actual_taken && bus.provider_ctr != '0)
      prov_ctr_next = bus.provider_ctr - 1'b1;
    prov_u_en   = (in_prov != '0) && (bus.taken_predicted != bus.alt_taken);
    prov_u_next = bus.provider_u;
    if (bus.taken_predicted == bus.actual_taken) begin
      if (bus.provider_u != U_MAX)
        prov_u_next = bus.provider_u + 1'b1;
    end else if (bus.provider_u != '0) begin
      prov_u_next = bus.provider_u - 1'b1;
    end
  end

  tage_alloc_picker #(
    .N_COMPONENTS (N_COMPONENTS),
    .U_WIDTH      (U_WIDTH)
  ) u_picker (
    .u_values (lat_uv),
    .provider (lat_prov),
    .lfsr_bit (lfsr[0]),
    .found    (pick_found),
    .chosen   (pick_comp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bus.wr_valid      <= 1'b0;
      bus.wr_component  <= '0;
      bus.wr_index      <= '0;
      bus.wr_ctr_en     <= 1'b0;
      bus.wr_u_en       <= 1'b0;
      bus.wr_tag_en     <= 1'b0;
      bus.wr_ctr        <= '0;
      bus.wr_u          <= '0;
      bus.wr_tag        <= '0;
      bus.u_clear_valid <= 1'b0;
      bus.u_clear_index <= '0;
      period_cnt        <= '0;
      sweep_pending     <= 1'b0;
      lfsr              <= LFSR_SEED;
    end else begin
      lfsr              <= lfsr_next(lfsr);
      bus.wr_valid      <= 1'b0;
      bus.wr_component  <= '0;
      bus.wr_index      <= '0;
      bus.wr_ctr_en     <= 1'b0;
      bus.wr_u_en       <= 1'b0;
      bus.wr_tag_en     <= 1'b0;
      bus.wr_ctr        <= '0;
      bus.wr_u          <= '0;
      bus.wr_tag        <= '0;
      bus.u_clear_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.update_valid) begin
            lat_actual       <= bus.actual_taken;
            lat_predicted    <= bus.taken_predicted;
            lat_prov         <= in_prov;
            lat_index        <= bus.entry_index;
            lat_tag          <= bus.entry_tag;
            lat_uv           <= bus.u_values;
            period_cnt       <= period_cnt + 1'b1;
            if (period_cnt == '1)
              sweep_pending  <= 1'b1;
            bus.wr_valid     <= 1'b1;
            bus.wr_component <= bus.provider_index;
            bus.wr_index     <= bus.entry_index[in_prov*INDEX_WIDTH +: INDEX_WIDTH];
            bus.wr_ctr_en    <= 1'b1;
            bus.wr_ctr       <= prov_ctr_next;
            bus.wr_u_en      <= prov_u_en;
            bus.wr_u         <= prov_u_en ? prov_u_next : '0;
            state            <= UPD_PROV;
          end
        end
        UPD_PROV: begin
          if (lat_predicted == lat_actual || lat_prov == LAST_COMP) begin
            state             <= sweep_pending ? SWEEP : IDLE;
            bus.u_clear_valid <= sweep_pending;
            bus.u_clear_index <= '0;
          end else if (pick_found) begin
            bus.wr_valid     <= 1'b1;
            bus.wr_component <= CW'(pick_comp);
            bus.wr_index     <= lat_index[pick_comp*INDEX_WIDTH +: INDEX_WIDTH];
            bus.wr_ctr_en    <= 1'b1;
            bus.wr_u_en      <= 1'b1;
            bus.wr_tag_en    <= 1'b1;
            bus.wr_ctr       <= lat_actual ? WEAK_T : WEAK_NT;
            bus.wr_tag       <= lat_tag[pick_comp*TAG_WIDTH +: TAG_WIDTH];
            state            <= ALLOC;
          end else begin
            dec_comp         <= dec_target;
            bus.wr_valid     <= 1'b1;
            bus.wr_component <= CW'(dec_target);
            bus.wr_index     <= lat_index[dec_target*INDEX_WIDTH +: INDEX_WIDTH];
            bus.wr_u_en      <= 1'b1;
            bus.wr_u         <= lat_uv[dec_target*U_WIDTH +: U_WIDTH] - 1'b1;
            state            <= U_DEC;
          end
        end
        ALLOC: begin
          state             <= sweep_pending ? SWEEP : IDLE;
          bus.u_clear_valid <= sweep_pending;
          bus.u_clear_index <= '0;
        end
        U_DEC: begin
          if (dec_comp == LAST_COMP) begin
            state             <= sweep_pending ? SWEEP : IDLE;
            bus.u_clear_valid <= sweep_pending;
            bus.u_clear_index <= '0;
          end else begin
            dec_comp         <= dec_target;
            bus.wr_valid     <= 1'b1;
            bus.wr_component <= CW'(dec_target);
            bus.wr_index     <= lat_index[dec_target*INDEX_WIDTH +: INDEX_WIDTH];
            bus.wr_u_en      <= 1'b1;
            bus.wr_u         <= lat_uv[dec_target*U_WIDTH +: U_WIDTH] - 1'b1;
          end
        end
        SWEEP: begin
          if (bus.u_clear_index == '1) begin
            sweep_pending <= 1'b0;
            state         <= IDLE;
          end else begin
            bus.u_clear_valid <= 1'b1;
            bus.u_clear_index <= bus.u_clear_index + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tage_updater.sv
// tb/tb_tage_updater.sv - randomized and directed checks of tage_updater against a reference model
module tb_tage_updater;

  localparam int N      = 5;
  localparam int CTR_W  = 3;
  localparam int U_W    = 2;
  localparam int TAG_W  = 8;
  localparam int IDX_W  = 4;
  localparam int PER_LG = 3;
  localparam int CTR_MAX_M = (1 << CTR_W) - 1;
  localparam int U_MAX_M   = (1 << U_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  tage_updater_if #(
    .N_COMPONENTS (N), .CTR_WIDTH (CTR_W), .U_WIDTH (U_W),
    .TAG_WIDTH (TAG_W), .INDEX_WIDTH (IDX_W)
  ) bus ();

  tage_updater #(
    .N_COMPONENTS (N), .CTR_WIDTH (CTR_W), .U_WIDTH (U_W), .TAG_WIDTH (TAG_W),
    .INDEX_WIDTH (IDX_W), .U_RESET_PERIOD_LOG2 (PER_LG)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int period_model = 0;

  logic [15:0] ref_lfsr;
  always @(posedge clk)
    ref_lfsr <= rst ? 16'h0001
                    : {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};

  typedef struct {
    int comp; int idx;
    bit ctr_en; bit u_en; bit tag_en;
    int ctr; int u; int tag;
  } wr_t;
  wr_t exp_q[$];

  int r_prov, r_ctr, r_u;
  bit r_act, r_tp, r_alt;
  int r_idx[N];
  int r_tag[N];
  int r_uv[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic set_rec(input int prov, input bit act, input bit tp, input bit alt,
                         input int ctr, input int u);
    r_prov = prov; r_act = act; r_tp = tp; r_alt = alt; r_ctr = ctr; r_u = u;
    for (int c = 0; c < N; c++) begin
      r_idx[c] = $urandom_range(0, (1 << IDX_W) - 1);
      r_tag[c] = $urandom_range(0, (1 << TAG_W) - 1);
      r_uv[c]  = $urandom_range(0, U_MAX_M);
    end
  endtask

  task automatic rand_rec();
    set_rec($urandom_range(0, N - 1), 1'($urandom), 1'($urandom), 1'($urandom),
            $urandom_range(0, CTR_MAX_M), $urandom_range(0, U_MAX_M));
  endtask

  function automatic void build_expected(input bit lfsr0);
    wr_t w;
    int free[$];
    int pick;
    exp_q.delete();
    w = '{comp: r_prov, idx: r_idx[r_prov], ctr_en: 1, u_en: 0, tag_en: 0,
          ctr: 0, u: 0, tag: 0};
    w.ctr = r_act ? ((r_ctr < CTR_MAX_M) ? r_ctr + 1 : CTR_MAX_M)
                  : ((r_ctr > 0) ? r_ctr - 1 : 0);
    if (r_prov != 0 && r_tp != r_alt) begin
      w.u_en = 1;
      w.u = (r_tp == r_act) ? ((r_u < U_MAX_M) ? r_u + 1 : U_MAX_M)
                            : ((r_u > 0) ? r_u - 1 : 0);
    end
    exp_q.push_back(w);
    if (r_tp != r_act && r_prov < N - 1) begin
      for (int j = r_prov + 1; j < N; j++)
        if (r_uv[j] == 0) free.push_back(j);
      if (free.size() > 0) begin
        pick = (lfsr0 && free.size() >= 2) ? free[1] : free[0];
        w = '{comp: pick, idx: r_idx[pick], ctr_en: 1, u_en: 1, tag_en: 1,
              ctr: r_act ? (1 << (CTR_W - 1)) : (1 << (CTR_W - 1)) - 1,
              u: 0, tag: r_tag[pick]};
        exp_q.push_back(w);
      end else begin
        for (int j = r_prov + 1; j < N; j++) begin
          w = '{comp: j, idx: r_idx[j], ctr_en: 0, u_en: 1, tag_en: 0,
                ctr: 0, u: r_uv[j] - 1, tag: 0};
          exp_q.push_back(w);
        end
      end
    end
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, "_wr_valid"}, bus.wr_valid, 0);
    check({tag, "_wr_en"}, {bus.wr_ctr_en, bus.wr_u_en, bus.wr_tag_en}, 0);
    check({tag, "_wr_comp_idx"}, {bus.wr_component, bus.wr_index}, 0);
    check({tag, "_clr_valid"}, bus.u_clear_valid, 0);
    check({tag, "_clr_index"}, bus.u_clear_index, 0);
    check({tag, "_ready"}, bus.update_ready, 1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    check_quiet("reset_abort");
    rst = 1'b0;
    period_model = 0;
  endtask

  // abort_wr / abort_sw: reset right after that write step / sweep step (-1 = none)
  task automatic run_update(input int abort_wr, input int abort_sw);
    int waited;
    int nq;
    int steps;
    bit sweep;
    waited = 0;
    while (!bus.update_ready && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_accept", bus.update_ready, 1);
    bus.update_valid    = 1'b1;
    bus.actual_taken    = r_act;
    bus.taken_predicted = r_tp;
    bus.alt_taken       = r_alt;
    bus.provider_index  = 3'(r_prov);
    bus.provider_ctr    = CTR_W'(r_ctr);
    bus.provider_u      = U_W'(r_u);
    for (int c = 0; c < N; c++) begin
      bus.entry_index[c*IDX_W +: IDX_W] = IDX_W'(r_idx[c]);
      bus.entry_tag[c*TAG_W +: TAG_W]   = TAG_W'(r_tag[c]);
      bus.u_values[c*U_W +: U_W]        = U_W'(r_uv[c]);
    end
    @(posedge clk); #1;
    bus.update_valid = 1'b0;
    bus.u_values     = 10'($urandom);
    bus.entry_index  = 20'($urandom);
    bus.entry_tag    = 40'({$urandom, $urandom});
    period_model = (period_model + 1) % (1 << PER_LG);
    sweep = (period_model == 0);
    build_expected(ref_lfsr[0]);
    nq = exp_q.size();
    steps = nq + (sweep ? (1 << IDX_W) : 0);
    for (int s = 0; s < steps; s++) begin
      check("ready_busy", bus.update_ready, 0);
      if (s < nq) begin
        check("wr_valid", bus.wr_valid, 1);
        check("clr_during_wr", bus.u_clear_valid, 0);
        check("wr_component", bus.wr_component, exp_q[s].comp);
        check("wr_index", bus.wr_index, exp_q[s].idx);
        check("wr_enables", {bus.wr_ctr_en, bus.wr_u_en, bus.wr_tag_en},
              {exp_q[s].ctr_en, exp_q[s].u_en, exp_q[s].tag_en});
        if (exp_q[s].ctr_en) check("wr_ctr", bus.wr_ctr, exp_q[s].ctr);
        if (exp_q[s].u_en)   check("wr_u", bus.wr_u, exp_q[s].u);
        if (exp_q[s].tag_en) check("wr_tag", bus.wr_tag, exp_q[s].tag);
      end else begin
        check("clr_valid", bus.u_clear_valid, 1);
        check("clr_index", bus.u_clear_index, s - nq);
        check("wr_during_clr", bus.wr_valid, 0);
      end
      if ((s < nq && s == abort_wr) || (s >= nq && s - nq == abort_sw)) begin
        apply_reset();
        return;
      end
      @(posedge clk); #1;
    end
    check("ready_after_seq", bus.update_ready, 1);
    check("idle_wr_valid", bus.wr_valid, 0);
    check("idle_clr_valid", bus.u_clear_valid, 0);
  endtask

  initial begin
    bus.update_valid = 1'b0; bus.actual_taken = 1'b0; bus.taken_predicted = 1'b0;
    bus.alt_taken = 1'b0; bus.provider_index = '0; bus.entry_index = '0;
    bus.entry_tag = '0; bus.provider_ctr = '0; bus.provider_u = '0; bus.u_values = '0;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("in_reset");
    rst = 1'b0;
    @(posedge clk); #1;
    check_quiet("after_reset");

    set_rec(0, 1, 1, 0, 3, 0); run_update(-1, -1);
    set_rec(2, 1, 1, 0, 7, 3); run_update(-1, -1);
    set_rec(1, 1, 0, 1, 2, 1); r_uv[2] = 1; r_uv[3] = 0; r_uv[4] = 0; run_update(-1, -1);
    set_rec(2, 0, 1, 0, 4, 2); r_uv[3] = 2; r_uv[4] = 1; run_update(-1, -1);
    set_rec(4, 1, 0, 0, 0, 1); run_update(-1, -1);
    set_rec(3, 0, 0, 1, 0, 0); run_update(-1, -1);
    set_rec(1, 0, 1, 1, 0, 3); r_uv[2] = 0; r_uv[3] = 3; r_uv[4] = 0; run_update(-1, -1);
    repeat (30) begin rand_rec(); run_update(-1, -1); end

    set_rec(1, 0, 1, 0, 5, 2); r_uv[2] = 0; r_uv[3] = 1; r_uv[4] = 0; run_update(1, -1);
    repeat (7) begin rand_rec(); run_update(-1, -1); end
    rand_rec(); run_update(-1, 5);
    repeat (8) begin rand_rec(); run_update(-1, -1); end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/tage_updater.md
# tage_updater

Update/allocation engine for the TAGE branch predictor: the resolve-time counterpart of the predict-time provider/alternate selector. It accepts one resolved branch (prediction metadata plus actual outcome) and serialises the resulting writes to the base and tagged component tables:
- provider counter/usefulness update;
- new-entry allocation on a misprediction;
- usefulness decay;
- periodic global usefulness reset.

Component 0 is the base bimodal table. Components 1..N_COMPONENTS-1 are tagged tables, with history length increasing with index.

## Interface
Parameters:
- N_COMPONENTS, 5, total components including base
- CTR_WIDTH, 3, prediction counter width (all components)
- U_WIDTH, 2, usefulness counter width (tagged only)
- TAG_WIDTH, 8, tagged-entry tag width
- INDEX_WIDTH, 10, table index width; each table has 2^INDEX_WIDTH entries
- U_RESET_PERIOD_LOG2, 18, accepted updates between global u resets

Ports (CW = $clog2(N_COMPONENTS)):
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- update_valid  in  1  resolved-branch record valid
- update_ready  out  1  engine idle, record accepted on valid&&ready
- actual_taken  in  1  resolved outcome
- taken_predicted  in  1  provider prediction
- alt_taken  in  1  alternate prediction
- provider_index  in  CW  provider component (0 = base)
- entry_index  in  N_COMPONENTS*INDEX_WIDTH  per-component index, slice c for component c
- entry_tag  in  N_COMPONENTS*TAG_WIDTH  per-component computed tag (slice 0 unused)
- provider_ctr  in  CTR_WIDTH  provider counter as read at predict
- provider_u  in  U_WIDTH  provider u (ignored for base)
- u_values  in  N_COMPONENTS*U_WIDTH  u read at each component's index (slice 0 unused)
- wr_valid  out  1  table write strobe
- wr_component  out  CW  target component
- wr_index  out  INDEX_WIDTH  target entry
- wr_ctr_en / wr_u_en / wr_tag_en  out  1 each  field enables
- wr_ctr  out  CTR_WIDTH, wr_u  out  U_WIDTH, wr_tag  out  TAG_WIDTH  write data
- u_clear_valid  out  1  clear u of entry u_clear_index in all tagged tables
- u_clear_index  out  INDEX_WIDTH  sweep index

## Operation
States: IDLE, UPD_PROV, ALLOC, U_DEC, SWEEP.

- **IDLE**
  - update_ready=1.
  - On accept: latch all inputs, increment the period counter, go to UPD_PROV.
- **UPD_PROV**: one write to provider_index at its entry_index.
  - ctr saturating ++ if actual_taken, else saturating --; wr_ctr_en=1.
  - If provider≠0 and taken_predicted≠alt_taken: u saturating ++ if taken_predicted==actual_taken, else saturating --; wr_u_en=1. Otherwise wr_u_en=0.
  - No misprediction, or provider==N_COMPONENTS-1: go to done.
  - Misprediction, some j>provider with u_values[j]==0: go to ALLOC.
  - Misprediction, no such j: go to U_DEC.
- **ALLOC**: free set F = {j > provider, u_values[j]==0}.
  - Pick the lowest member of F, except pick the second-lowest when lfsr[0]==1 and |F|≥2.
  - Write tag=entry_tag[j], u=0, ctr=weak (2^(CTR_WIDTH-1) if actual_taken, else 2^(CTR_WIDTH-1)-1); all three enables set.
  - Go to done.
- **U_DEC**: for each j from provider+1 to N_COMPONENTS-1 in ascending order, one cycle each, write u=u_values[j]-1 (all are ≥1 here), wr_u_en only. Then go to done.
- **done**: if sweep_pending, go to SWEEP; else IDLE.
- **Period counter**: counts accepted updates. On wrap to 0, set sweep_pending.
- **SWEEP**:
  - u_clear_valid=1, u_clear_index counts 0..2^INDEX_WIDTH-1, one per cycle.
  - After the last index: clear sweep_pending, go to IDLE.
- **LFSR**: 16-bit, x^16+x^14+x^13+x^11+1, seed 16'h0001. Advances every cycle.

## Timing
- Accept at edge T. Provider write valid during cycle T+1. ALLOC or the first U_DEC write during T+2.
- update_ready=1 only in IDLE; earliest next accept is the cycle after the last write or sweep cycle.
- All outputs registered except update_ready, which is decoded from state.
- Reset (sync):
  - state IDLE; wr_* and u_clear_* all 0.
  - Period counter 0, sweep_pending 0, LFSR seed.
  - update_ready=1 from the first cycle with rst low.
  - rst mid-operation aborts any pending writes or sweep immediately.
- wr_valid and u_clear_valid are never high in the same cycle.
- u_values are latched at accept; table writes made during the sequence do not affect the decision.

## Structure
- Package tage_pkg:
  - state enum;
  - component-index typedef;
  - weak-taken/weak-not-taken constant functions of CTR_WIDTH;
  - LFSR polynomial constant.
- Sub-module tage_alloc_picker: combinational; inputs are latched u_values, provider, and LFSR bit; outputs are found and chosen component.

## Test plan
Configuration: N=5, CTR_WIDTH=3, U_WIDTH=2, INDEX_WIDTH=4, U_RESET_PERIOD_LOG2=3.
- Correct base prediction, provider=0, ctr=3, taken -> a single write: comp 0, ctr=4, wr_u_en=0; ready returns at T+2.
- provider=2, ctr=7, u=3, taken_predicted=1, alt=0, actual=1 -> ctr stays 7 (saturated), u stays 3, no allocation.
- Mispredict, provider=1, u_values[2..4]={1,0,0}, lfsr[0]=0 -> ALLOC comp 3, tag=entry_tag[3], ctr=4 when actual=1, u=0.
- Mispredict, provider=2, u_values[3..4]={2,1} -> U_DEC writes comp 3 u=1, then comp 4 u=0, on consecutive cycles.
- Eighth accepted update -> after its writes, 16 u_clear cycles with indices 0..15, ready low throughout, then IDLE.
- rst asserted during ALLOC cycle or mid-sweep -> next cycle all outputs 0, ready=1, fresh 8-update period.
